// File: rtl/idma_cmd_arbiter_if.sv
// Single stream channel (data/valid/last/ready) used for every command and response port of
// idma_cmd_arbiter.
interface idma_cmd_arbiter_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic        tready;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/idma_cmd_arbiter.sv
// Shares one iDMA engine between the tx (port 0) and rx (port 1) command streams and routes
// each response back by grant order. Define IDMA_ARB_FIXED_PRIO_EN for fixed port-0 priority.
//
// state   | meaning
// S_IDLE  | no packet in flight; arbitration decision registered here
// S_GRANT | granted port's command packet passes through to iDMA until tlast
module idma_cmd_arbiter #(
  parameter int unsigned ORDER_DEPTH = 4
) (
  input  logic                aclk,
  input  logic                areset,
  idma_cmd_arbiter_if.slave   c0_s,
  idma_cmd_arbiter_if.slave   c1_s,
  idma_cmd_arbiter_if.master  idma_m,
  idma_cmd_arbiter_if.slave   idma_s,
  idma_cmd_arbiter_if.master  r0_m,
  idma_cmd_arbiter_if.master  r1_m,
  output logic                orphan_rsp
);

  localparam int unsigned AW = (ORDER_DEPTH > 1) ? $clog2(ORDER_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  logic [0:0]    state_q, state_d;
  logic          grant_q, grant_d;
  logic          pick;

  logic          fifo_q [ORDER_DEPTH];
  logic [AW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;
  logic          fifo_empty, fifo_full, head_id;
  logic          push, pop;

  logic          orphan_q, orphan_d;

  logic          sel_valid, sel_last;
  logic [31:0]   sel_data;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(ORDER_DEPTH));
  assign head_id    = fifo_q[head_q];

`ifdef IDMA_ARB_FIXED_PRIO_EN
  assign pick = c0_s.tvalid ? 1'b0 : 1'b1;
`else
  logic rr_ptr_q;

  assign pick = (c0_s.tvalid && c1_s.tvalid) ? rr_ptr_q : c1_s.tvalid;

  // Whoever just finished a packet yields the next tie to the other port.
  always_ff @(posedge aclk) begin
    if (areset) begin
      rr_ptr_q <= 1'b0;
    end else if (push) begin
      rr_ptr_q <= ~grant_q;
    end
  end
`endif

  assign sel_valid = grant_q ? c1_s.tvalid : c0_s.tvalid;
  assign sel_last  = grant_q ? c1_s.tlast  : c0_s.tlast;
  assign sel_data  = grant_q ? c1_s.tdata  : c0_s.tdata;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    push         = 1'b0;
    idma_m.tdata  = '0;
    idma_m.tvalid = 1'b0;
    idma_m.tlast  = 1'b0;
    c0_s.tready   = 1'b0;
    c1_s.tready   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((c0_s.tvalid || c1_s.tvalid) && !fifo_full) begin
          grant_d = pick;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        idma_m.tdata  = sel_data;
        idma_m.tvalid = sel_valid;
        idma_m.tlast  = sel_last;
        if (grant_q) begin
          c1_s.tready = idma_m.tready;
        end else begin
          c0_s.tready = idma_m.tready;
        end
        if (sel_valid && idma_m.tready && sel_last) begin
          push    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Responses follow the FIFO head; with nothing outstanding they are swallowed.
  always_comb begin
    r0_m.tdata  = idma_s.tdata;
    r0_m.tlast  = idma_s.tlast;
    r0_m.tvalid = idma_s.tvalid && !fifo_empty && !head_id;
    r1_m.tdata  = idma_s.tdata;
    r1_m.tlast  = idma_s.tlast;
    r1_m.tvalid = idma_s.tvalid && !fifo_empty && head_id;
    if (areset) begin
      idma_s.tready = 1'b0;
    end else if (fifo_empty) begin
      idma_s.tready = 1'b1;
    end else begin
      idma_s.tready = head_id ? r1_m.tready : r0_m.tready;
    end
    pop      = idma_s.tvalid && idma_s.tready && idma_s.tlast && !fifo_empty;
    orphan_d = idma_s.tvalid && idma_s.tready && fifo_empty;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= S_IDLE;
      grant_q  <= 1'b0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      orphan_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      orphan_q <= orphan_d;
      if (push) begin
        tail_q <= tail_q + AW'(1);
      end
      if (pop) begin
        head_q <= head_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (push) begin
      fifo_q[tail_q] <= grant_q;
    end
  end

  assign orphan_rsp = orphan_q;

endmodule

// File: tb/tb_idma_cmd_arbiter.sv
// Directed bench for idma_cmd_arbiter: packet arbitration, order FIFO steering, full stall,
// orphan responses, push/pop overlap and reset mid-packet.
module tb_idma_cmd_arbiter;
  logic aclk = 1'b0;
  logic areset;
  logic orphan_rsp;
  int   checks = 0;
  int   errors = 0;

  idma_cmd_arbiter_if c0_if ();
  idma_cmd_arbiter_if c1_if ();
  idma_cmd_arbiter_if im_if ();
  idma_cmd_arbiter_if is_if ();
  idma_cmd_arbiter_if r0_if ();
  idma_cmd_arbiter_if r1_if ();

  always #5 aclk = ~aclk;

  idma_cmd_arbiter #(.ORDER_DEPTH(4)) dut (
    .aclk       (aclk),
    .areset     (areset),
    .c0_s       (c0_if),
    .c1_s       (c1_if),
    .idma_m     (im_if),
    .idma_s     (is_if),
    .r0_m       (r0_if),
    .r1_m       (r1_if),
    .orphan_rsp (orphan_rsp)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge aclk);
    #2;
  endtask

  task automatic c0_drv(input logic v, input logic [31:0] d, input logic l);
    c0_if.tvalid = v; c0_if.tdata = d; c0_if.tlast = l;
  endtask

  task automatic c1_drv(input logic v, input logic [31:0] d, input logic l);
    c1_if.tvalid = v; c1_if.tdata = d; c1_if.tlast = l;
  endtask

  task automatic rsp_drv(input logic v, input logic [31:0] d);
    is_if.tvalid = v; is_if.tdata = d; is_if.tlast = v;
  endtask

  // One packet from a single port: idle/arbitration cycle then three beats.
  task automatic pkt(input int port, input logic [31:0] base);
    if (port == 0) c0_drv(1'b1, base, 1'b0); else c1_drv(1'b1, base, 1'b0);
    #1;
    chk("pkt_arb_tready", (port == 0) ? c0_if.tready : c1_if.tready, 0);
    chk("pkt_arb_mvalid", im_if.tvalid, 0);
    nxt();
    for (int b = 0; b < 3; b++) begin
      if (port == 0) c0_drv(1'b1, base + b, b == 2); else c1_drv(1'b1, base + b, b == 2);
      #1;
      chk("pkt_mvalid", im_if.tvalid, 1);
      chk("pkt_mdata", im_if.tdata, base + b);
      chk("pkt_mlast", im_if.tlast, (b == 2) ? 1 : 0);
      chk("pkt_own_tready", (port == 0) ? c0_if.tready : c1_if.tready, 1);
      chk("pkt_other_tready", (port == 0) ? c1_if.tready : c0_if.tready, 0);
      nxt();
    end
    if (port == 0) c0_drv(1'b0, 32'h0, 1'b0); else c1_drv(1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    areset = 1'b1;
    c0_drv(1'b0, 32'h0, 1'b0);
    c1_drv(1'b0, 32'h0, 1'b0);
    rsp_drv(1'b0, 32'h0);
    im_if.tready = 1'b1;
    r0_if.tready = 1'b1;
    r1_if.tready = 1'b1;
    nxt();
    nxt();
    #1;
    chk("rst_mvalid", im_if.tvalid, 0);
    chk("rst_c0_tready", c0_if.tready, 0);
    chk("rst_c1_tready", c1_if.tready, 0);
    chk("rst_s_tready", is_if.tready, 0);
    chk("rst_r0_tvalid", r0_if.tvalid, 0);
    chk("rst_r1_tvalid", r1_if.tvalid, 0);
    chk("rst_orphan", orphan_rsp, 0);
    chk("rst_count", 32'(dut.count_q), 0);
    areset = 1'b0;
    #1;
    chk("idle_s_tready_empty", is_if.tready, 1);
    nxt();

    // Single-port packet from tx
    pkt(0, 32'hA000_0000);
    #1;
    chk("t1_count", 32'(dut.count_q), 1);
    chk("t1_mvalid_after", im_if.tvalid, 0);

    areset = 1'b1;
    nxt();
    #1;
    chk("t2_rst_count", 32'(dut.count_q), 0);
    areset = 1'b0;

    // Both ports valid after reset: tx first, one idle cycle, then rx
    c0_drv(1'b1, 32'hC000_0000, 1'b0);
    c1_drv(1'b1, 32'hC100_0000, 1'b0);
    #1;
    chk("t2_arb_c0_tready", c0_if.tready, 0);
    chk("t2_arb_c1_tready", c1_if.tready, 0);
    nxt();
    for (int b = 0; b < 3; b++) begin
      c0_drv(1'b1, 32'hC000_0000 + b, b == 2);
      #1;
      chk("t2_c0_mdata", im_if.tdata, 32'hC000_0000 + b);
      chk("t2_c0_tready", c0_if.tready, 1);
      chk("t2_c1_blocked", c1_if.tready, 0);
      nxt();
    end
    c0_drv(1'b0, 32'h0, 1'b0);
    #1;
    chk("t2_gap_mvalid", im_if.tvalid, 0);
    chk("t2_gap_count", 32'(dut.count_q), 1);
    nxt();
    for (int b = 0; b < 3; b++) begin
      c1_drv(1'b1, 32'hC100_0000 + b, b == 2);
      #1;
      chk("t2_c1_mdata", im_if.tdata, 32'hC100_0000 + b);
      chk("t2_c1_tready", c1_if.tready, 1);
      chk("t2_c0_tready_off", c0_if.tready, 0);
      nxt();
    end
    c1_drv(1'b0, 32'h0, 1'b0);
    #1;
    chk("t2_count", 32'(dut.count_q), 2);

    // Responses return in grant order {0,1}
    r0_if.tready = 1'b0;
    rsp_drv(1'b1, 32'h0001_0040);
    #1;
    chk("t3_r0_tvalid", r0_if.tvalid, 1);
    chk("t3_backpressure", is_if.tready, 0);
    nxt();
    r0_if.tready = 1'b1;
    #1;
    chk("t3_s_tready", is_if.tready, 1);
    chk("t3_r0_tdata", r0_if.tdata, 32'h0001_0040);
    chk("t3_r1_quiet", r1_if.tvalid, 0);
    nxt();
    rsp_drv(1'b1, 32'h0002_0080);
    #1;
    chk("t3_r1_tvalid", r1_if.tvalid, 1);
    chk("t3_r1_tdata", r1_if.tdata, 32'h0002_0080);
    chk("t3_r0_quiet", r0_if.tvalid, 0);
    nxt();
    rsp_drv(1'b0, 32'h0);
    #1;
    chk("t3_count", 32'(dut.count_q), 0);

    // Fill the order FIFO; fifth packet must stall until a response pops
    for (int i = 0; i < 4; i++) pkt(0, 32'hB000_0000 + (i << 8));
    #1;
    chk("t4_full_count", 32'(dut.count_q), 4);
    c0_drv(1'b1, 32'hD000_0000, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t4_stall_tready", c0_if.tready, 0);
      chk("t4_stall_mvalid", im_if.tvalid, 0);
      nxt();
    end
    rsp_drv(1'b1, 32'h0000_0001);
    #1;
    chk("t4_pop_r0", r0_if.tvalid, 1);
    chk("t4_pop_tready", c0_if.tready, 0);
    nxt();
    rsp_drv(1'b0, 32'h0);
    #1;
    chk("t4_arb_mvalid", im_if.tvalid, 0);
    chk("t4_count3", 32'(dut.count_q), 3);
    nxt();
    for (int b = 0; b < 3; b++) begin
      c0_drv(1'b1, 32'hD000_0000 + b, b == 2);
      #1;
      chk("t4_5th_mvalid", im_if.tvalid, 1);
      chk("t4_5th_mdata", im_if.tdata, 32'hD000_0000 + b);
      nxt();
    end
    c0_drv(1'b0, 32'h0, 1'b0);
    #1;
    chk("t4_refull", 32'(dut.count_q), 4);
    for (int i = 0; i < 4; i++) begin
      rsp_drv(1'b1, 32'h0000_0010 + i);
      #1;
      chk("t4_drain_r0", r0_if.tvalid, 1);
      chk("t4_drain_r1", r1_if.tvalid, 0);
      nxt();
    end
    rsp_drv(1'b0, 32'h0);
    #1;
    chk("t4_drained", 32'(dut.count_q), 0);

    // Orphan response
    rsp_drv(1'b1, 32'h0003_00C0);
    #1;
    chk("t5_s_tready", is_if.tready, 1);
    chk("t5_r0_tvalid", r0_if.tvalid, 0);
    chk("t5_r1_tvalid", r1_if.tvalid, 0);
    chk("t5_orphan_pre", orphan_rsp, 0);
    nxt();
    rsp_drv(1'b0, 32'h0);
    #1;
    chk("t5_orphan_pulse", orphan_rsp, 1);
    nxt();
    #1;
    chk("t5_orphan_end", orphan_rsp, 0);

    // Pop of an rx response coincides with the last beat of a tx packet
    pkt(1, 32'hE100_0000);
    c0_drv(1'b1, 32'hE000_0000, 1'b0);
    nxt();
    c0_drv(1'b1, 32'hE000_0000, 1'b0);
    nxt();
    c0_drv(1'b1, 32'hE000_0001, 1'b0);
    nxt();
    c0_drv(1'b1, 32'hE000_0002, 1'b1);
    rsp_drv(1'b1, 32'h0004_0100);
    #1;
    chk("t6_overlap_mlast", im_if.tlast, 1);
    chk("t6_overlap_r1", r1_if.tvalid, 1);
    chk("t6_overlap_r0", r0_if.tvalid, 0);
    nxt();
    c0_drv(1'b0, 32'h0, 1'b0);
    rsp_drv(1'b0, 32'h0);
    #1;
    chk("t6_count_same", 32'(dut.count_q), 1);
    r0_if.tready = 1'b0;
    rsp_drv(1'b1, 32'h0005_0140);
    #1;
    chk("t6_next_r0", r0_if.tvalid, 1);
    chk("t6_next_r1", r1_if.tvalid, 0);
    chk("t6_next_stall", is_if.tready, 0);
    nxt();
    rsp_drv(1'b0, 32'h0);
    r0_if.tready = 1'b1;

    // Reset during the second beat of an rx packet
    c1_drv(1'b1, 32'hF000_0000, 1'b0);
    nxt();
    nxt();
    c1_drv(1'b1, 32'hF000_0001, 1'b0);
    areset = 1'b1;
    #1;
    chk("t7_mid_mdata", im_if.tdata, 32'hF000_0001);
    nxt();
    #1;
    chk("t7_mvalid", im_if.tvalid, 0);
    chk("t7_c0_tready", c0_if.tready, 0);
    chk("t7_c1_tready", c1_if.tready, 0);
    chk("t7_s_tready", is_if.tready, 0);
    chk("t7_r0_tvalid", r0_if.tvalid, 0);
    chk("t7_r1_tvalid", r1_if.tvalid, 0);
    chk("t7_count", 32'(dut.count_q), 0);
    c1_drv(1'b0, 32'h0, 1'b0);
    areset = 1'b0;
    #1;
    chk("t7_post_s_tready", is_if.tready, 1);
    chk("t7_post_mvalid", im_if.tvalid, 0);
    nxt();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
